// File: rtl/countup_timer.sv
// countup_timer: seconds count-up timer with a pause/resume/clear FSM.
// CU counts counted ticks from 0 up to LIMIT. It stops in DONE and holds there
// until a start reloads it or a clear returns it to IDLE. tens and ones are a
// registered BCD copy of CU that is updated on the same edge as CU.
module countup_timer #(
    parameter logic [4:0] LIMIT = 5'd30   // terminal count in ticks, 1..31
) (
    input  logic       CK,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [4:0] CU,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       cu_done,
    output logic       done_pulse,
    output logic [1:0] state_dbg
);

    // Control semantics: tick, start, pause and clear are level-sampled at
    // every rising CK edge. There is no handshake, and a control held high
    // acts on each edge it is seen. When several controls are high on the
    // same edge, rst wins over clear, clear over start, start over pause,
    // and pause over tick. A lower-priority control that loses is dropped.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [4:0] LIMIT_M1 = LIMIT - 5'd1;

    state_t     state_q, state_d;
    logic [4:0] cu_q, cu_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       pulse_q, pulse_d;

    // Binary 0..31 to two BCD digits by subtracting the tens boundaries.
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] t;
        logic [4:0] r;
        t = 4'd0;
        r = v;
        if (v >= 5'd30) begin
            t = 4'd3;
            r = v - 5'd30;
        end else if (v >= 5'd20) begin
            t = 4'd2;
            r = v - 5'd20;
        end else if (v >= 5'd10) begin
            t = 4'd1;
            r = v - 5'd10;
        end
        return {t, r[3:0]};
    endfunction

    // Next-state, next-count and completion pulse, following the control priority above.
    always_comb begin
        state_d = state_q;
        cu_d    = cu_q;
        pulse_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            cu_d    = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        cu_d    = 5'd0;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        cu_d    = 5'd0;
                    end
                end
                ST_PAUSED: begin
                    // Resume keeps the frozen count.
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is meaningless while running, so pause is evaluated next.
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        if (cu_q >= LIMIT_M1) begin
                            cu_d    = LIMIT;
                            state_d = ST_DONE;
                            pulse_d = 1'b1;
                        end else begin
                            cu_d = cu_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cu_d    = 5'd0;
                end
            endcase
        end
    end

    // The BCD digits are taken from the next count so they land on the same edge as CU.
    always_comb begin
        tens_d = 4'd0;
        ones_d = 4'd0;
        {tens_d, ones_d} = to_bcd(cu_d);
    end

    // State, count, digits and pulse registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cu_q    <= 5'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cu_q    <= cu_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            pulse_q <= pulse_d;
        end
    end

    assign CU         = cu_q;
    assign tens       = tens_q;
    assign ones       = ones_q;
    assign done_pulse = pulse_q;
    assign running    = (state_q == ST_RUN);
    assign cu_done    = (state_q == ST_DONE);
    assign state_dbg  = state_q;

endmodule

// File: doc/countup_timer.md
COUNTUP_TIMER -- requirements
Module: countup_timer

Interface
REQ-001 SHALL have parameter LIMIT, default 5'd30, meaning terminal count in ticks; legal range 1..31.
REQ-002 SHALL have port CK  input  1  rising-edge system clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port tick  input  1  one-CK-wide count enable, one pulse per elapsed second.
REQ-005 SHALL have port start  input  1  begin counting from IDLE or DONE, or resume from PAUSED.
REQ-006 SHALL have port pause  input  1  freeze count while running.
REQ-007 SHALL have port clear  input  1  abort to IDLE with count zero.
REQ-008 SHALL have port CU  output  5  elapsed count, binary, 0..LIMIT.
REQ-009 SHALL have port tens  output  4  BCD tens digit of CU.
REQ-010 SHALL have port ones  output  4  BCD ones digit of CU.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port cu_done  output  1  level, high while in DONE.
REQ-013 SHALL have port done_pulse  output  1  single-CK pulse on reaching LIMIT.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSED and DONE.
REQ-015 SHALL resolve same-cycle controls by priority: rst, then clear, then start, then pause, then tick.
REQ-016 SHALL, on clear in any state, go to IDLE with CU=0 on the next edge.
REQ-017 SHALL, in IDLE, go to RUN on start with CU=0; tick in the same cycle is not counted.
REQ-018 SHALL, in DONE, go to RUN on start with CU reloaded to 0; tick in the same cycle is not counted.
REQ-019 SHALL, in PAUSED, go to RUN on start with CU held; tick in the same cycle is not counted.
REQ-020 SHALL ignore start while in RUN; pause in the same cycle is then evaluated as normal.
REQ-021 SHALL, in RUN, go to PAUSED on pause; tick in the same cycle is not counted.
REQ-022 SHALL, in RUN with tick and no higher-priority control, increment CU by 1.
REQ-023 SHALL, on the tick taking CU from LIMIT-1 to LIMIT, go to DONE and assert done_pulse for exactly the following one cycle.
REQ-024 SHALL hold CU at LIMIT in DONE; tick and pause are ignored, and CU never exceeds LIMIT or wraps.
REQ-025 SHALL ignore tick and pause in IDLE and PAUSED.
REQ-026 SHALL register tens and ones in the same edge as CU, so all three are mutually consistent every cycle with zero-cycle skew.
REQ-027 SHALL have tens = CU/10 and ones = CU mod 10, valid for 0..31.
REQ-028 SHALL make running and cu_done registered state decodes, asserted on the cycle after the transitioning edge.
REQ-029 SHALL, with LIMIT=1, enter DONE on the first counted tick after start.

Reset
REQ-030 SHALL, while rst=1 at a CK edge, set state IDLE, CU=0, tens=0, ones=0, running=0, cu_done=0 and done_pulse=0.
REQ-031 SHALL, on rst asserted mid-RUN or mid-DONE, abandon the count with no done_pulse, with rst overriding all other inputs.
REQ-032 SHALL leave all outputs at reset values after rst deasserts until a start is sampled.

Verification
REQ-033 SHALL verify: rst, start, then 30 ticks (LIMIT=30) -> CU steps 0..30, tens/ones 3/0 at end, done_pulse high 1 cycle, cu_done high, running low.
REQ-034 SHALL verify: in RUN at CU=12, pause with tick same cycle, then 5 ticks, then start -> CU stays 12 throughout, next tick gives 13, tens/ones 1/3.
REQ-035 SHALL verify: in DONE, 3 extra ticks -> CU stays 30 with no further done_pulse; then start -> CU=0, running=1.
REQ-036 SHALL verify: clear and start same cycle while at CU=7 in RUN -> IDLE, CU=0, running=0.
REQ-037 SHALL verify: rst at CU=29 with tick same cycle -> CU=0, no done_pulse, all outputs reset.
REQ-038 SHALL verify: LIMIT=1, start then one tick -> CU=1, done_pulse one cycle, cu_done=1.
